fifo_status: RTL and testbench

//  Next-generation async-FIFO status generator; one instance per clock domain.

---
 rtl/fifo_pkg.sv | 38 +++
 rtl/gray2bin_w.sv | 22 ++
 rtl/fifo_status.sv | 134 +++++++++++++
 tb/tb_fifo_status.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO status generators and pointer blocks:
// mode encoding, depth derivation and Gray/binary conversion helpers.
package fifo_pkg;

  // Which side of the FIFO a status instance lives on.
  localparam int unsigned MODE_EMPTY = 0;  // read domain: empty / almost-empty
  localparam int unsigned MODE_FULL  = 1;  // write domain: full / almost-full

  // Widest pointer the helper functions handle; narrower pointers are zero-extended.
  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  // Number of words in a FIFO with the given address width.
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Binary -> reflected Gray code.
  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  // Zero-extended upper bits contribute nothing, so any width <= PTR_MAX_W works.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    logic      parity;
    bin    = '0;
    parity = 1'b0;
    for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
      parity = parity ^ gray[i];
      bin[i] = parity;
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_w.sv
// Width-parametrised Gray -> binary converter, purely combinational.
module gray2bin_w #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // XOR prefix running from the MSB down to the LSB.
  always_comb begin
    logic parity;
    // NOTE: every combinational output gets a default before any conditional
    // or looped assignment so no path can leave it unassigned (no latch).
    bin    = '0;
    parity = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      parity = parity ^ gray[i];
      bin[i] = parity;
    end
  end

endmodule

// File: rtl/fifo_status.sv
// Async-FIFO status generator, one instance per clock domain.
// MODE_EMPTY (read side) produces empty/almost-empty, MODE_FULL (write side)
// produces full/almost-full; both produce a saturated occupancy level and a
// sticky error for under/overflow attempts or impossible occupancy.
// Two register stages: pointers/threshold are registered, then decoded and
// compared, so every output is a flop and pointer changes show 2 cycles later.
module fifo_status
  import fifo_pkg::*;
#(
  parameter int unsigned MODE       = MODE_EMPTY,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   ptr_lc,
  input  logic [ADDR_WIDTH:0]   ptr_rmt,
  input  logic [ADDR_WIDTH:0]   thr,
  input  logic                  acc,
  input  logic                  err_clr,
  output logic                  flag,
  output logic                  almost,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  err
);

  // Pointer width including the wrap bit.
  localparam int unsigned    PW       = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]  DEPTH_W  = PW'(fifo_depth(ADDR_WIDTH));
  localparam logic           IS_EMPTY = (MODE == MODE_EMPTY);
  // The empty side comes out of reset reporting empty; the full side reports not-full.
  localparam logic           FLAG_RST = IS_EMPTY;

  // ---------------------------------------------------------------------------
  // Stage 1: capture local/remote Gray pointers and the threshold.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] lc_gray_d,  lc_gray_q;
  logic [PW-1:0] rmt_gray_d, rmt_gray_q;
  logic [PW-1:0] thr_d,      thr_q;

  // Next values of the stage-1 registers, cleared while reset is held.
  always_comb begin
    lc_gray_d  = ptr_lc;
    rmt_gray_d = ptr_rmt;
    thr_d      = thr;
    // NOTE: the reset is synchronous, so it is folded into the _d logic and the
    // flop process below stays a plain clocked copy with no reset branch.
    if (!rst_n) begin
      lc_gray_d  = '0;
      rmt_gray_d = '0;
      thr_d      = '0;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement or process order.
    lc_gray_q  <= lc_gray_d;
    rmt_gray_q <= rmt_gray_d;
    thr_q      <= thr_d;
  end

  // Decode both registered pointers to binary.
  logic [PW-1:0] lb;
  logic [PW-1:0] rb;

  gray2bin_w #(.WIDTH(PW)) u_lc_g2b (
    .gray (lc_gray_q),
    .bin  (lb)
  );

  gray2bin_w #(.WIDTH(PW)) u_rmt_g2b (
    .gray (rmt_gray_q),
    .bin  (rb)
  );

  // ---------------------------------------------------------------------------
  // Stage 2: occupancy, flags, level and the sticky error.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] occ;       // raw occupancy, modulo 2**PW
  logic          corrupt;   // occupancy beyond what the FIFO can hold
  logic [PW-1:0] occ_sat;   // occupancy clamped to DEPTH
  logic [PW-1:0] thr_eff;   // threshold clamped to DEPTH
  logic [PW-1:0] room;      // free slots, from the clamped occupancy

  // Occupancy and clamped operands; modulo subtraction handles pointer wrap.
  always_comb begin
    occ     = IS_EMPTY ? (rb - lb) : (lb - rb);
    corrupt = (occ > DEPTH_W);
    occ_sat = corrupt ? DEPTH_W : occ;
    thr_eff = (thr_q > DEPTH_W) ? DEPTH_W : thr_q;
    room    = DEPTH_W - occ_sat;
  end

  logic          flag_d,   flag_q;
  logic          almost_d, almost_q;
  logic [PW-1:0] level_d,  level_q;
  logic          err_d,    err_q;

  // Next status values; reset forces the side-specific idle indication.
  always_comb begin
    level_d = occ_sat;
    if (IS_EMPTY) begin
      flag_d   = (occ == '0);
      almost_d = (occ_sat <= thr_eff);
    end else begin
      flag_d   = (occ == DEPTH_W);
      almost_d = (room <= thr_eff);
    end
    // Access against a set flag, or an impossible occupancy, sets the error;
    // setting takes priority over a simultaneous clear.
    err_d = (acc & flag_q) | corrupt | (err_q & ~err_clr);
    if (!rst_n) begin
      level_d  = '0;
      flag_d   = FLAG_RST;
      almost_d = FLAG_RST;
      err_d    = 1'b0;
    end
  end

  // Stage-2 (output) registers.
  always_ff @(posedge clk) begin
    flag_q   <= flag_d;
    almost_q <= almost_d;
    level_q  <= level_d;
    err_q    <= err_d;
  end

  assign flag   = flag_q;
  assign almost = almost_q;
  assign level  = level_q;
  assign err    = err_q;

endmodule

// File: tb/tb_fifo_status.sv
// Self-checking bench for fifo_status: one empty-side and one full-side
// instance, each fed by its own write/read pointer pair. Expected outputs come
// from a reference model that tracks occupancy as (write - read) and delays it
// through the two-cycle status latency.
module tb_fifo_status;

  localparam int AW    = 4;
  localparam int W     = AW + 1;
  localparam int DEPTH = 16;
  localparam int MASK  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] ptr_lc  [2];
  logic [W-1:0] ptr_rmt [2];
  logic [W-1:0] thr;
  logic         acc;
  logic         err_clr;
  logic         flag    [2];
  logic         almost  [2];
  logic [W-1:0] level   [2];
  logic         err     [2];

  always #5 clk = ~clk;

  fifo_status #(.MODE(0), .ADDR_WIDTH(AW)) u_empty (
    .clk     (clk),
    .rst_n   (rst_n),
    .ptr_lc  (ptr_lc[0]),
    .ptr_rmt (ptr_rmt[0]),
    .thr     (thr),
    .acc     (acc),
    .err_clr (err_clr),
    .flag    (flag[0]),
    .almost  (almost[0]),
    .level   (level[0]),
    .err     (err[0])
  );

  fifo_status #(.MODE(1), .ADDR_WIDTH(AW)) u_full (
    .clk     (clk),
    .rst_n   (rst_n),
    .ptr_lc  (ptr_lc[1]),
    .ptr_rmt (ptr_rmt[1]),
    .thr     (thr),
    .acc     (acc),
    .err_clr (err_clr),
    .flag    (flag[1]),
    .almost  (almost[1]),
    .level   (level[1]),
    .err     (err[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus: binary write/read pointers per instance (index 0 = empty side).
  int wr [2];
  int rd [2];

  // Model: pointer/threshold values seen one edge ago, and expected outputs.
  int s1_wr [2];
  int s1_rd [2];
  int s1_thr;
  bit exp_flag   [2];
  bit exp_almost [2];
  int exp_level  [2];
  bit exp_err    [2];

  function automatic logic [W-1:0] to_gray(input int b);
    logic [W-1:0] v;
    v = W'(b & MASK);
    return v ^ (v >> 1);
  endfunction

  // The read side's local pointer is the read pointer; the write side's is the write pointer.
  task automatic drive_ptrs();
    ptr_lc[0]  = to_gray(rd[0]);
    ptr_rmt[0] = to_gray(wr[0]);
    ptr_lc[1]  = to_gray(wr[1]);
    ptr_rmt[1] = to_gray(rd[1]);
  endtask

  task automatic model_edge();
    int  occ;
    int  occ_s;
    int  t;
    bit  bad;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        s1_wr[m]      = 0;
        s1_rd[m]      = 0;
        exp_flag[m]   = (m == 0);
        exp_almost[m] = (m == 0);
        exp_level[m]  = 0;
        exp_err[m]    = 1'b0;
      end
      s1_thr = 0;
    end else begin
      t = (s1_thr > DEPTH) ? DEPTH : s1_thr;
      for (int m = 0; m < 2; m++) begin
        occ   = (s1_wr[m] - s1_rd[m]) & MASK;
        bad   = (occ > DEPTH);
        occ_s = bad ? DEPTH : occ;
        exp_err[m]    = (acc && exp_flag[m]) || bad || (exp_err[m] && !err_clr);
        exp_flag[m]   = (m == 0) ? (occ == 0) : (occ == DEPTH);
        exp_almost[m] = (m == 0) ? (occ_s <= t) : ((DEPTH - occ_s) <= t);
        exp_level[m]  = occ_s;
      end
      for (int m = 0; m < 2; m++) begin
        s1_wr[m] = wr[m] & MASK;
        s1_rd[m] = rd[m] & MASK;
      end
      s1_thr = int'(thr);
    end
  endtask

  // One clock: drive pointers, advance the model at the edge, compare after it.
  task automatic tick();
    drive_ptrs();
    @(posedge clk);
    model_edge();
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d flag", m),   32'(flag[m]),   32'(exp_flag[m]));
      check($sformatf("m%0d almost", m), 32'(almost[m]), 32'(exp_almost[m]));
      check($sformatf("m%0d level", m),  32'(level[m]),  32'(exp_level[m]));
      check($sformatf("m%0d err", m),    32'(err[m]),    32'(exp_err[m]));
    end
  endtask

  initial begin
    int occ;
    int bias;

    rst_n   = 1'b0;
    acc     = 1'b0;
    err_clr = 1'b0;
    thr     = '0;
    for (int m = 0; m < 2; m++) begin
      wr[m] = 0;
      rd[m] = 0;
    end

    // Reset with both pointers at zero, then hold through release.
    repeat (3) tick();
    check("rst empty flag",   32'(flag[0]),   32'd1);
    check("rst empty almost", 32'(almost[0]), 32'd1);
    check("rst empty level",  32'(level[0]),  32'd0);
    check("rst full flag",    32'(flag[1]),   32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("release empty flag",  32'(flag[0]),  32'd1);
    check("release empty level", 32'(level[0]), 32'd0);
    check("release empty err",   32'(err[0]),   32'd0);

    // Empty side: remote write pointer steps to 5 with thr=3.
    thr   = W'(3);
    wr[0] = 5;
    tick();
    tick();
    check("t2 level",  32'(level[0]),  32'd5);
    check("t2 flag",   32'(flag[0]),   32'd0);
    check("t2 almost", 32'(almost[0]), 32'd0);
    rd[0] = 2;
    tick();
    tick();
    check("t2b level",  32'(level[0]),  32'd3);
    check("t2b almost", 32'(almost[0]), 32'd1);

    // Full side: 16 words written, then an overflow attempt, then clear.
    wr[1] = 16;
    rd[1] = 0;
    tick();
    tick();
    check("t3 flag",  32'(flag[1]),  32'd1);
    check("t3 level", 32'(level[1]), 32'd16);
    acc = 1'b1;
    tick();
    acc = 1'b0;
    check("t3 overflow err", 32'(err[1]), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3 cleared err", 32'(err[1]), 32'd0);

    // Full side across the wrap: write at 3, read at 20 -> 15 words.
    thr   = W'(1);
    wr[1] = 3;
    rd[1] = 20;
    tick();
    tick();
    check("t4 level",  32'(level[1]),  32'd15);
    check("t4 flag",   32'(flag[1]),   32'd0);
    check("t4 almost", 32'(almost[1]), 32'd1);

    // Empty side corruption: 18 words apart saturates and flags the error.
    rd[0] = 0;
    wr[0] = 18;
    tick();
    tick();
    check("t5 err",   32'(err[0]),   32'd1);
    check("t5 level", 32'(level[0]), 32'd16);
    wr[0] = 0;
    tick();
    tick();
    check("t5 empty flag", 32'(flag[0]), 32'd1);
    acc     = 1'b1;
    err_clr = 1'b1;
    tick();
    check("t5 set beats clear", 32'(err[0]), 32'd1);
    acc = 1'b0;
    tick();
    err_clr = 1'b0;
    check("t5 clear", 32'(err[0]), 32'd0);

    // Reset mid-run with 9 words buffered.
    wr[0] = 9;
    tick();
    tick();
    check("t6 level before", 32'(level[0]), 32'd9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6 level", 32'(level[0]), 32'd0);
    check("t6 flag",  32'(flag[0]),  32'd1);
    check("t6 err",   32'(err[0]),   32'd0);
    tick();
    check("t6 hold level", 32'(level[0]), 32'd0);
    tick();
    tick();
    check("t6 level back", 32'(level[0]), 32'd9);

    // Randomised traffic: alternating fill/drain bias, occasional corruption,
    // resets, threshold changes, accesses and error clears.
    for (int c = 0; c < 800; c++) begin
      bias    = (c / 100) % 2;
      rst_n   = ($urandom_range(0, 79) != 0);
      acc     = ($urandom_range(0, 2) == 0);
      err_clr = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) thr = W'($urandom_range(0, 31));
      for (int m = 0; m < 2; m++) begin
        occ = (wr[m] - rd[m]) & MASK;
        if (occ > DEPTH) begin
          if ($urandom_range(0, 3) == 0) rd[m] = wr[m];
        end else begin
          if ((occ < DEPTH) && ($urandom_range(0, 3) < ((bias == 1) ? 3 : 1)))
            wr[m] = (wr[m] + 1) & MASK;
          if ((occ > 0) && ($urandom_range(0, 3) < ((bias == 1) ? 1 : 3)))
            rd[m] = (rd[m] + 1) & MASK;
          if ($urandom_range(0, 99) == 0)
            wr[m] = (rd[m] + int'($urandom_range(17, 31))) & MASK;
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
